// File: rtl/cmd_dispatch_pkg.sv
// Shared types and constants for the command dispatcher.
// Opcodes, FSM states and response bytes.
package cmd_pkg;

  typedef enum logic [3:0] {
    OP_CAL     = 4'h0,
    OP_MOVE    = 4'h2,
    OP_MOVE_FF = 4'h3,
    OP_TOUR    = 4'h4
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAL,
    S_MOVE,
    S_TOUR,
    S_RESP,
    S_TX_WAIT
  } state_t;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_ERR = 8'hEE;
  localparam logic [7:0] RESP_TMO = 8'hE0;

  // A zero heading field means "no turn"; otherwise pad the low nibble.
  function automatic logic [11:0] mk_heading(
    input logic [7:0] h
  );
    if (h == 8'h00) return 12'h000;
    return {h, 4'hF};
  endfunction

endpackage

// File: rtl/cmd_dispatch_if.sv
// Bundle of command, engine and UART handshakes
// seen by the dispatcher.
interface cmd_dispatch_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        strt_cal;
  logic        cal_done;
  logic        move_req;
  logic [11:0] heading;
  logic [3:0]  squares;
  logic        fanfare;
  logic        move_done;
  logic        start_tour;
  logic [5:0]  tour_xy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;

  modport slave (
    input  cmd, cmd_rdy, cal_done,
    input  move_done, tx_done,
    output clr_cmd_rdy, strt_cal, move_req,
    output heading, squares, fanfare,
    output start_tour, tour_xy, trmt, resp
  );

  modport master (
    output cmd, cmd_rdy, cal_done,
    output move_done, tx_done,
    input  clr_cmd_rdy, strt_cal, move_req,
    input  heading, squares, fanfare,
    input  start_tour, tour_xy, trmt, resp
  );
endinterface

// File: rtl/cmd_dispatch_timer.sv
// Wait-state timeout counter: cleared on command
// accept, counts while enabled, flags the last cycle.
module cmd_timer #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int TMO_W =
    $clog2(int'(TIMEOUT_CYC) + 1);
  localparam logic [TMO_W-1:0] LAST =
    TMO_W'(TIMEOUT_CYC - 24'd1);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);
endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: accepts one UART command, drives
// the engine handshakes and returns a response byte.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input logic           clk,
  input logic           rst,
  cmd_dispatch_if.slave bus
);
  state_t      state_q, state_d;
  logic        first_q;
  logic [7:0]  resp_q, resp_d;
  logic [11:0] heading_q;
  logic [3:0]  squares_q;
  logic        fanfare_q;
  logic [5:0]  tour_xy_q;
  logic [3:0]  op;
  logic        accept;
  logic        waiting;
  logic        expired;

  assign op      = bus.cmd[15:12];
  assign accept  = (state_q == S_IDLE)
                 && bus.cmd_rdy;
  assign waiting = (state_q == S_CAL)
                 || (state_q == S_MOVE);

  cmd_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (accept),
    .en_i     (waiting),
    .expired_o(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
      resp_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      resp_q  <= resp_d;
    end
  end

  // Done beats expiry when both land in one cycle.
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_rdy) begin
          case (op)
            OP_CAL:  state_d = S_CAL;
            OP_MOVE,
            OP_MOVE_FF: state_d = S_MOVE;
            OP_TOUR: state_d = S_TOUR;
            default: begin
              state_d = S_RESP;
              resp_d  = RESP_ERR;
            end
          endcase
        end
      end
      S_CAL: begin
        if (bus.cal_done) begin
          state_d = S_RESP;
          resp_d  = RESP_ACK;
        end else if (expired) begin
          state_d = S_RESP;
          resp_d  = RESP_TMO;
        end
      end
      S_MOVE: begin
        if (bus.move_done) begin
          state_d = S_RESP;
          resp_d  = RESP_ACK;
        end else if (expired) begin
          state_d = S_RESP;
          resp_d  = RESP_TMO;
        end
      end
      S_TOUR:  state_d = S_IDLE;
      S_RESP:  state_d = S_TX_WAIT;
      S_TX_WAIT: begin
        if (bus.tx_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      heading_q <= 12'h000;
      squares_q <= 4'h0;
      fanfare_q <= 1'b0;
      tour_xy_q <= 6'h00;
    end else if (accept) begin
      unique case (1'b1)
        (op == OP_MOVE),
        (op == OP_MOVE_FF): begin
          heading_q <= mk_heading(bus.cmd[11:4]);
          squares_q <= bus.cmd[3:0];
          fanfare_q <= (op == OP_MOVE_FF);
        end
        (op == OP_TOUR): begin
          tour_xy_q <= {bus.cmd[6:4], bus.cmd[2:0]};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.clr_cmd_rdy = accept;
    bus.strt_cal    = (state_q == S_CAL)
                    && first_q;
    bus.move_req    = (state_q == S_MOVE)
                    && first_q;
    bus.start_tour  = (state_q == S_TOUR);
    bus.trmt        = (state_q == S_RESP);
    bus.resp        = resp_q;
    bus.heading     = heading_q;
    bus.squares     = squares_q;
    bus.fanfare     = fanfare_q;
    bus.tour_xy     = tour_xy_q;
  end
endmodule

// File: tb/tb_cmd_dispatch.sv
// Randomized and directed bench for cmd_dispatch
// against a cycle-count reference model.
module tb_cmd_dispatch;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_dispatch_if bus();

  cmd_dispatch #(
    .TIMEOUT_CYC(24'd100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // observed
  int o_end, o_busy_clr;
  int o_strt_cnt, o_strt_cyc;
  int o_mv_cnt, o_mv_cyc;
  int o_tour_cnt, o_tour_cyc;
  int o_trmt_cnt, o_trmt_cyc;
  logic        o_clr0, o_clr_end, o_ff;
  logic [11:0] o_hd;
  logic [3:0]  o_sq;
  logic [5:0]  o_txy;
  logic [7:0]  o_resp, o_resp_tx;

  // expected
  int e_kind, e_trmt_cyc;
  logic [7:0]  e_resp;
  logic [11:0] e_hd;
  logic [3:0]  e_sq;
  logic        e_ff;
  logic [5:0]  m_txy;

  // kind: 0 cal, 1 move, 2 tour, 3 invalid.
  // d = cycles after the start pulse at which
  // done is pulsed, -1 for never.
  task automatic model(input logic [15:0] c,
                       input int d);
    int op;
    bit ok;
    op = int'(c[15:12]);
    if (op == 0) e_kind = 0;
    else if (op == 2 || op == 3) e_kind = 1;
    else if (op == 4) e_kind = 2;
    else e_kind = 3;
    ok = (d >= 0) && (d < TMO);
    e_trmt_cyc = -1;
    e_resp = 8'h00;
    if (e_kind < 2) begin
      e_trmt_cyc = ok ? d + 2 : TMO + 1;
      e_resp = ok ? 8'hA5 : 8'hE0;
    end else if (e_kind == 3) begin
      e_trmt_cyc = 1;
      e_resp = 8'hEE;
    end
    e_hd = 12'h000;
    if (c[11:4] != 8'h00)
      e_hd = 12'(int'(c[11:4]) * 16 + 15);
    e_sq = c[3:0];
    e_ff = (op == 3);
    if (e_kind == 2) m_txy = {c[6:4], c[2:0]};
  endtask

  // Starts and ends just after a falling edge.
  task automatic run_cmd(input logic [15:0] c,
                         input int d,
                         input int txd,
                         input bit hold,
                         input bit xtalk);
    bit is_cal, is_mv;
    int txc;
    is_cal = (c[15:12] == 4'h0);
    is_mv  = (c[15:12] == 4'h2)
          || (c[15:12] == 4'h3);
    o_end = -1; o_busy_clr = 0;
    o_strt_cnt = 0; o_strt_cyc = -1;
    o_mv_cnt = 0; o_mv_cyc = -1;
    o_tour_cnt = 0; o_tour_cyc = -1;
    o_trmt_cnt = 0; o_trmt_cyc = -1;
    o_resp = 8'h00; o_resp_tx = 8'h00;
    o_hd = 12'h000; o_sq = 4'h0; o_ff = 1'b0;
    o_clr_end = 1'b0;
    txc = -1;
    bus.cmd = c;
    bus.cmd_rdy = 1'b1;
    #1 o_clr0 = bus.clr_cmd_rdy;
    for (int cy = 1; cy <= 400; cy++) begin
      @(negedge clk);
      bus.cal_done = 1'b0;
      bus.move_done = 1'b0;
      bus.tx_done = 1'b0;
      if (!hold) bus.cmd_rdy = 1'b0;
      if (d >= 0 && cy == 1 + d) begin
        if (is_cal) bus.cal_done = 1'b1;
        if (is_mv) bus.move_done = 1'b1;
      end
      if (xtalk && o_trmt_cnt == 0) begin
        if (is_cal) bus.move_done = 1'b1;
        if (is_mv) bus.cal_done = 1'b1;
      end
      if (xtalk && o_trmt_cyc > 0
          && cy == o_trmt_cyc + 1) begin
        if (is_cal) bus.cal_done = 1'b1;
        if (is_mv) bus.move_done = 1'b1;
      end
      if (o_trmt_cyc > 0
          && cy == o_trmt_cyc + txd) begin
        bus.tx_done = 1'b1;
        txc = cy;
      end
      #1;
      if ((txc > 0 && cy == txc + 1) ||
          (o_tour_cyc > 0 && cy == o_tour_cyc + 1)) begin
        o_end = cy;
        o_clr_end = bus.clr_cmd_rdy;
        o_txy = bus.tour_xy;
        break;
      end
      if (bus.clr_cmd_rdy) o_busy_clr++;
      if (bus.strt_cal) begin
        o_strt_cnt++; o_strt_cyc = cy;
      end
      if (bus.move_req) begin
        o_mv_cnt++; o_mv_cyc = cy;
        o_hd = bus.heading;
        o_sq = bus.squares;
        o_ff = bus.fanfare;
      end
      if (bus.start_tour) begin
        o_tour_cnt++; o_tour_cyc = cy;
      end
      if (bus.trmt) begin
        o_trmt_cnt++; o_trmt_cyc = cy;
        o_resp = bus.resp;
      end
      if (cy == txc) o_resp_tx = bus.resp;
    end
  endtask

  task automatic test_reset();
    bus.cmd = 16'h0000; bus.cmd_rdy = 1'b0;
    bus.cal_done = 1'b0; bus.move_done = 1'b0;
    bus.tx_done = 1'b0;
    rst = 1'b1;
    m_txy = 6'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.clr_cmd_rdy, bus.strt_cal,
         bus.move_req, bus.heading, bus.squares,
         bus.fanfare, bus.start_tour, bus.tour_xy,
         bus.trmt, bus.resp} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
  endtask

  task automatic test_cal();
    model(16'h0000, 50);
    run_cmd(16'h0000, 50, 3, 1'b0, 1'b0);
    n_chk++;
    if (o_clr0 !== 1'b1) begin
      n_fail++;
      $display("FAIL cal_clr: got %b want 1", o_clr0);
    end
    n_chk++;
    if (o_strt_cyc !== 1 || o_strt_cnt !== 1) begin
      n_fail++;
      $display("FAIL cal_strt: got cyc %0d cnt %0d want 1 1",
               o_strt_cyc, o_strt_cnt);
    end
    n_chk++;
    if (o_trmt_cyc !== e_trmt_cyc || o_resp !== e_resp) begin
      n_fail++;
      $display("FAIL cal_resp: got cyc %0d %h want %0d %h",
               o_trmt_cyc, o_resp, e_trmt_cyc, e_resp);
    end
    n_chk++;
    if (o_end !== e_trmt_cyc + 4 || o_resp_tx !== e_resp) begin
      n_fail++;
      $display("FAIL cal_txdone: got end %0d %h want %0d %h",
               o_end, o_resp_tx, e_trmt_cyc + 4, e_resp);
    end
  endtask

  task automatic test_move();
    logic [15:0] cv[2];
    int dv[2];
    cv[0] = 16'h33F2; dv[0] = 10;
    cv[1] = 16'h2002; dv[1] = 0;
    for (int i = 0; i < 2; i++) begin
      model(cv[i], dv[i]);
      run_cmd(cv[i], dv[i], 1, 1'b0, 1'b0);
      n_chk++;
      if ({o_hd, o_sq, o_ff} !== {e_hd, e_sq, e_ff}
          || o_mv_cyc !== 1) begin
        n_fail++;
        $display("FAIL move_fields %h: got %h %h %b cyc %0d want %h %h %b 1",
                 cv[i], o_hd, o_sq, o_ff, o_mv_cyc,
                 e_hd, e_sq, e_ff);
      end
      n_chk++;
      if (o_trmt_cyc !== e_trmt_cyc || o_resp !== e_resp) begin
        n_fail++;
        $display("FAIL move_resp %h: got %0d %h want %0d %h",
                 cv[i], o_trmt_cyc, o_resp,
                 e_trmt_cyc, e_resp);
      end
    end
  endtask

  task automatic test_tour_invalid();
    model(16'h4035, -1);
    run_cmd(16'h4035, -1, 1, 1'b0, 1'b0);
    n_chk++;
    if (o_tour_cnt !== 1 || o_tour_cyc !== 1
        || o_trmt_cnt !== 0) begin
      n_fail++;
      $display("FAIL tour_pulse: got cnt %0d cyc %0d trmt %0d want 1 1 0",
               o_tour_cnt, o_tour_cyc, o_trmt_cnt);
    end
    n_chk++;
    if (o_txy !== 6'b011_101) begin
      n_fail++;
      $display("FAIL tour_xy: got %b want 011101", o_txy);
    end
    model(16'h9000, -1);
    run_cmd(16'h9000, -1, 2, 1'b0, 1'b0);
    n_chk++;
    if (o_trmt_cyc !== 1 || o_resp !== 8'hEE
        || o_strt_cnt + o_mv_cnt + o_tour_cnt !== 0) begin
      n_fail++;
      $display("FAIL invalid_resp: got cyc %0d %h want 1 ee",
               o_trmt_cyc, o_resp);
    end
  endtask

  task automatic test_timeout();
    int late;
    model(16'h2105, -1);
    run_cmd(16'h2105, -1, 2, 1'b0, 1'b1);
    n_chk++;
    if (o_trmt_cyc - o_mv_cyc !== TMO
        || o_resp !== 8'hE0 || o_trmt_cnt !== 1) begin
      n_fail++;
      $display("FAIL timeout: got gap %0d %h cnt %0d want %0d e0 1",
               o_trmt_cyc - o_mv_cyc, o_resp,
               o_trmt_cnt, TMO);
    end
    late = 0;
    repeat (5) begin
      @(negedge clk);
      #1 if (bus.trmt) late++;
    end
    n_chk++;
    if (late !== 0) begin
      n_fail++;
      $display("FAIL late_done: got %0d trmt want 0", late);
    end
  endtask

  task automatic test_race();
    int dv[2];
    dv[0] = TMO - 1;
    dv[1] = TMO;
    for (int i = 0; i < 2; i++) begin
      model(16'h2011, dv[i]);
      run_cmd(16'h2011, dv[i], 1, 1'b0, 1'b0);
      n_chk++;
      if (o_trmt_cyc !== e_trmt_cyc || o_resp !== e_resp) begin
        n_fail++;
        $display("FAIL race d=%0d: got %0d %h want %0d %h",
                 dv[i], o_trmt_cyc, o_resp,
                 e_trmt_cyc, e_resp);
      end
    end
  endtask

  task automatic test_back_to_back();
    model(16'h9000, -1);
    run_cmd(16'h9000, -1, 4, 1'b1, 1'b0);
    n_chk++;
    if (o_busy_clr !== 0 || o_clr_end !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_clr: got busy %0d idle %b want 0 1",
               o_busy_clr, o_clr_end);
    end
    model(16'h0000, 5);
    run_cmd(16'h0000, 5, 1, 1'b0, 1'b0);
    n_chk++;
    if (o_strt_cyc !== 1 || o_trmt_cyc !== e_trmt_cyc
        || o_resp !== e_resp) begin
      n_fail++;
      $display("FAIL b2b: got %0d %0d %h want 1 %0d %h",
               o_strt_cyc, o_trmt_cyc, o_resp,
               e_trmt_cyc, e_resp);
    end
  endtask

  task automatic test_reset_mid();
    int late;
    bus.cmd = 16'h2123; bus.cmd_rdy = 1'b1;
    @(negedge clk);
    bus.cmd_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_txy = 6'h00;
    #1;
    n_chk++;
    if ({bus.clr_cmd_rdy, bus.strt_cal,
         bus.move_req, bus.heading, bus.squares,
         bus.fanfare, bus.start_tour, bus.tour_xy,
         bus.trmt, bus.resp} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got nonzero outputs, want all 0");
    end
    late = 0;
    repeat (TMO + 10) begin
      @(negedge clk);
      #1 if (bus.trmt) late++;
    end
    n_chk++;
    if (late !== 0) begin
      n_fail++;
      $display("FAIL reset_abort: got %0d trmt want 0", late);
    end
    model(16'h0000, 3);
    run_cmd(16'h0000, 3, 2, 1'b0, 1'b0);
    n_chk++;
    if (o_strt_cyc !== 1 || o_trmt_cyc !== e_trmt_cyc
        || o_resp !== e_resp) begin
      n_fail++;
      $display("FAIL post_reset_cal: got %0d %0d %h want 1 %0d %h",
               o_strt_cyc, o_trmt_cyc, o_resp,
               e_trmt_cyc, e_resp);
    end
  endtask

  task automatic test_random();
    logic [3:0] ops[7];
    logic [15:0] c;
    int d, r, txd;
    bit xt;
    ops = '{4'h0, 4'h2, 4'h3, 4'h4,
            4'h9, 4'hF, 4'h1};
    for (int n = 0; n < 24; n++) begin
      c = {ops[$urandom_range(0, 6)],
           12'($urandom)};
      r = int'($urandom_range(0, 9));
      if (r == 0) d = -1;
      else if (r == 1) d = TMO - 1;
      else if (r == 2) d = TMO;
      else d = int'($urandom_range(0, 40));
      txd = int'($urandom_range(1, 4));
      xt = 1'($urandom_range(0, 1));
      model(c, d);
      run_cmd(c, d, txd, 1'b0, xt);
      n_chk++;
      if (o_clr0 !== 1'b1 || o_end < 0
          || o_busy_clr !== 0) begin
        n_fail++;
        $display("FAIL rnd_flow %h: got clr %b end %0d busy %0d",
                 c, o_clr0, o_end, o_busy_clr);
      end
      n_chk++;
      if (o_strt_cnt !== int'(e_kind == 0)
          || o_mv_cnt !== int'(e_kind == 1)
          || o_tour_cnt !== int'(e_kind == 2)) begin
        n_fail++;
        $display("FAIL rnd_pulses %h: got %0d %0d %0d kind %0d",
                 c, o_strt_cnt, o_mv_cnt,
                 o_tour_cnt, e_kind);
      end
      n_chk++;
      if (o_trmt_cyc !== e_trmt_cyc
          || o_resp !== e_resp) begin
        n_fail++;
        $display("FAIL rnd_resp %h d=%0d: got %0d %h want %0d %h",
                 c, d, o_trmt_cyc, o_resp,
                 e_trmt_cyc, e_resp);
      end
      if (e_kind == 1) begin
        n_chk++;
        if ({o_hd, o_sq, o_ff}
            !== {e_hd, e_sq, e_ff}) begin
          n_fail++;
          $display("FAIL rnd_move %h: got %h %h %b want %h %h %b",
                   c, o_hd, o_sq, o_ff,
                   e_hd, e_sq, e_ff);
        end
      end
      if (e_kind == 2) begin
        n_chk++;
        if (o_txy !== m_txy) begin
          n_fail++;
          $display("FAIL rnd_tour %h: got %b want %b",
                   c, o_txy, m_txy);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cal();
    test_move();
    test_tour_invalid();
    test_timeout();
    test_race();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
- Consumes the 16-bit commands assembled by the UART wrapper (cmd, cmd_rdy) and acknowledges each one with clr_cmd_rdy.
- Decodes the opcode and drives calibration, move and tour-start handshakes to the downstream engines.
- Waits for completion or a timeout, then returns a one-byte response through the UART transmit path (trmt, resp, tx_done).
- Accepts exactly one command at a time.

Parameters:
- TIMEOUT_CYC, 24'd10_000_000: cycles allowed for cal_done or move_done before an error response.
- TMO_W, $clog2(TIMEOUT_CYC+1): width of the timeout counter. Derived; not overridden.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd  in  16  command word; [15:12] opcode, [11:0] operands
- cmd_rdy  in  1  level; cmd is valid
- clr_cmd_rdy  out  1  one-cycle pulse; command accepted
- strt_cal  out  1  one-cycle pulse; start calibration
- cal_done  in  1  calibration complete (pulse or level)
- move_req  out  1  one-cycle pulse; start move
- heading  out  12  move heading, held while in MOVE
- squares  out  4  move distance in squares, held while in MOVE
- fanfare  out  1  move-with-fanfare flag, held while in MOVE
- move_done  in  1  move complete
- start_tour  out  1  one-cycle pulse; start tour
- tour_xy  out  6  tour start square {x[2:0], y[2:0]}, held until the next tour command
- trmt  out  1  one-cycle pulse; send resp
- resp  out  8  response byte, stable from trmt until tx_done
- tx_done  in  1  UART transmit complete

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst); all state changes on posedge clk.
- Reset values: state IDLE, every output 0, timeout counter 0. Reset asserted mid-operation aborts immediately with no response sent. Any pending cmd_rdy is not cleared by this block.
- Opcodes (cmd[15:12]):
  - 0x0 CAL
  - 0x2 MOVE
  - 0x3 MOVE_FANFARE
  - 0x4 TOUR
  - anything else INVALID
- IDLE:
  - On cmd_rdy=1, clr_cmd_rdy is asserted combinationally in that same cycle.
  - On the same edge, the opcode and operands are registered and the next state is chosen.
  - cmd_rdy is never accepted outside IDLE; it stays pending until IDLE returns.
- CAL:
  - strt_cal pulses in the first cycle of CAL.
  - Wait for cal_done, then load resp=8'hA5 and go to RESP.
- MOVE (opcode 0x2 or 0x3):
  - heading = (cmd[11:4]==0) ? 12'h000 : {cmd[11:4], 4'hF}.
  - squares = cmd[3:0]; fanfare = (opcode==0x3).
  - move_req pulses in the first cycle of MOVE.
  - Wait for move_done, then resp=8'hA5 and go to RESP.
  - squares==0 is still issued as a move. Zero-distance handling belongs downstream.
- TOUR:
  - Load tour_xy={cmd[6:4], cmd[2:0]}.
  - start_tour pulses for one cycle, then return to IDLE.
  - No response is sent; the tour logic owns further responses.
- INVALID: resp=8'hEE, go to RESP directly.
- Timeout:
  - The counter clears on entry to CAL or MOVE and increments each cycle while waiting.
  - On reaching TIMEOUT_CYC-1 without done: resp=8'hE0, go to RESP.
  - If done and expiry occur in the same cycle, done wins (resp=8'hA5).
  - Late done pulses arriving after a timeout are ignored.
- Cross-talk: cal_done is ignored outside CAL and move_done outside MOVE.
- RESP: trmt pulses for exactly one cycle, then go to TX_WAIT.
- TX_WAIT:
  - Stay until tx_done=1, sampled starting the cycle after trmt; then go to IDLE.
  - No timeout here.
- Latency, best case: cmd_rdy accepted at edge N, strt_cal/move_req high in cycle N+1. Done seen at edge M gives trmt in cycle M+1.
- Back-to-back: a new command can be accepted in the first IDLE cycle after tx_done.

Decomposition:
- Package cmd_pkg holds:
  - opcode_t enum (CAL, MOVE, MOVE_FF, TOUR)
  - state_t enum (IDLE, CAL, MOVE, TOUR, RESP, TX_WAIT)
  - constants RESP_ACK=8'hA5, RESP_ERR=8'hEE, RESP_TMO=8'hE0
- Sub-module cmd_timer: counter with clr and en inputs and an expired output, parameterised by TIMEOUT_CYC.

Test Plan:
- Calibration: cmd=16'h0000 with cmd_rdy → clr_cmd_rdy in the same cycle; strt_cal 1 cycle later; cal_done after 50 cycles → trmt pulse with resp=8'hA5; tx_done → IDLE.
- Move with fanfare: cmd=16'h33F2 → heading=12'h3FF, squares=2, fanfare=1, move_req pulse. Repeat with cmd=16'h2002 → heading=12'h000, fanfare=0.
- Tour: cmd=16'h4035 → start_tour pulse, tour_xy=6'b011_101, no trmt. Separately, cmd=16'h9000 → resp=8'hEE.
- Timeout: TIMEOUT_CYC=100, MOVE, no move_done → trmt with resp=8'hE0 exactly 100 cycles after move_req; a later move_done has no effect.
- Busy and races:
  - cmd_rdy held during TX_WAIT → no clr_cmd_rdy until IDLE.
  - move_done coincident with timeout expiry → resp=8'hA5.
- Reset mid-MOVE: rst for 1 cycle → all outputs 0; a following cmd=16'h0000 runs normally.
